// File: rtl/mcycle_pkg.sv
// Shared encodings, state type and sizing constants for the multi-cycle
// multiply/divide unit.
package mcycle_pkg;

  localparam int MC_WIDTH = 32;
  localparam int MC_CNT_W = $clog2(MC_WIDTH);

  // MCycleOp[1] selects the operation, MCycleOp[0] the signedness
  localparam logic MC_MUL      = 1'b0;
  localparam logic MC_DIV      = 1'b1;
  localparam logic MC_SIGNED   = 1'b0;
  localparam logic MC_UNSIGNED = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } mc_state_e;

endpackage

// File: rtl/mcycle_if.sv
// Request/response bundle between the E-stage/hazard logic (master) and the
// multi-cycle unit (slave).
interface mcycle_if
  import mcycle_pkg::*;
#(
  parameter int WIDTH = MC_WIDTH
);
  logic             Start;
  logic [1:0]       MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [3:0]       WA3E;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;
  logic             Done;
  logic [3:0]       WA3R;

  modport master (
    output Start, MCycleOp, Operand1, Operand2, WA3E,
    input  Result1, Result2, Busy, Done, WA3R
  );

  modport slave (
    input  Start, MCycleOp, Operand1, Operand2, WA3E,
    output Result1, Result2, Busy, Done, WA3R
  );
endinterface

// File: rtl/mcycle_iter.sv
// One combinational iteration on the {hi, lo} working register: shift-add for
// multiply, restoring compare/subtract-shift for divide.
module mcycle_iter #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;

  always_comb begin
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : '0);
    rem  = {hi_i, lo_i[WIDTH-1]};
    diff = rem - {1'b0, m_i};
    if (is_div_i) begin
      // hi holds the partial remainder, lo shifts dividend out and quotient in
      if (rem >= {1'b0, m_i}) begin
        hi_o = diff[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        hi_o = rem[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mcycle_unit.sv
// Multi-cycle multiply/divide responder: IDLE -> COMPUTE (WIDTH iterations)
// -> DONE, with sign fix-up applied as the last iteration completes.
module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int WIDTH = MC_WIDTH
) (
  input  logic     CLK,
  input  logic     RESET,
  mcycle_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  mc_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;
  logic             neg_q;
  logic             negr_q;
  logic             div0_q;
  logic [WIDTH-1:0] op1_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] res1_q;
  logic [WIDTH-1:0] res2_q;
  logic [3:0]       wa3r_q;

  logic             a_neg, b_neg, sgn;
  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] res1_d, res2_d;

  mcycle_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div_i (is_div_q),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .m_i      (m_q),
    .hi_o     (hi_n),
    .lo_o     (lo_n)
  );

  always_comb begin
    sgn   = (bus.MCycleOp[0] == MC_SIGNED);
    a_neg = sgn & bus.Operand1[WIDTH-1];
    b_neg = sgn & bus.Operand2[WIDTH-1];
    abs1  = a_neg ? -bus.Operand1 : bus.Operand1;
    abs2  = b_neg ? -bus.Operand2 : bus.Operand2;
    prod  = {hi_n, lo_n};
    if (neg_q) prod = -prod;
    // divide-by-zero bypasses the iterated result but keeps the same latency
    if (!is_div_q) begin
      res1_d = prod[WIDTH-1:0];
      res2_d = prod[2*WIDTH-1:WIDTH];
    end else if (div0_q) begin
      res1_d = '1;
      res2_d = op1_q;
    end else begin
      res1_d = neg_q  ? -lo_n : lo_n;
      res2_d = negr_q ? -hi_n : hi_n;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      div0_q   <= 1'b0;
      op1_q    <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res1_q   <= '0;
      res2_q   <= '0;
      wa3r_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.Start) begin
            is_div_q <= (bus.MCycleOp[1] == MC_DIV);
            neg_q    <= a_neg ^ b_neg;
            negr_q   <= a_neg;
            div0_q   <= (bus.Operand2 == '0);
            op1_q    <= bus.Operand1;
            wa3r_q   <= bus.WA3E;
            hi_q     <= '0;
            // multiply iterates over |Operand2| with |Operand1| as addend;
            // divide shifts |Operand1| out against divisor |Operand2|
            m_q      <= (bus.MCycleOp[1] == MC_DIV) ? abs2 : abs1;
            lo_q     <= (bus.MCycleOp[1] == MC_DIV) ? abs1 : abs2;
            cnt_q    <= '0;
            state_q  <= COMPUTE;
          end
        end
        COMPUTE: begin
          hi_q  <= hi_n;
          lo_q  <= lo_n;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            res1_q  <= res1_d;
            res2_q  <= res2_d;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Busy    = (state_q == COMPUTE);
  assign bus.Done    = (state_q == DONE);
  assign bus.Result1 = res1_q;
  assign bus.Result2 = res2_q;
  assign bus.WA3R    = wa3r_q;

endmodule

// File: tb/tb_mcycle_unit.sv
// Randomized and directed bench for mcycle_unit against an arithmetic
// reference model using 64-bit integer operators.
module tb_mcycle_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mcycle_if #(.WIDTH(W)) bus ();

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r1, output logic [31:0] r2);
    longint sa, sb;
    logic [63:0] p, q, r;
    sa = $signed(a);
    sb = $signed(b);
    if (!op[1]) begin
      if (op[0]) p = {32'b0, a} * {32'b0, b};
      else       p = sa * sb;
      r1 = p[31:0];
      r2 = p[63:32];
    end else if (b == 32'd0) begin
      r1 = 32'hFFFF_FFFF;
      r2 = a;
    end else if (op[0]) begin
      r1 = a / b;
      r2 = a % b;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      r1 = q[31:0];
      r2 = r[31:0];
    end
  endtask

  task automatic drive(input logic st, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] wa);
    bus.Start    = st;
    bus.MCycleOp = op;
    bus.Operand1 = a;
    bus.Operand2 = b;
    bus.WA3E     = wa;
  endtask

  // Waits for Done; n counts edges since the accept edge already consumed.
  task automatic wait_done(inout int n, output int bad);
    bad = 0;
    while (!bus.Done && n < 100) begin
      if (!bus.Busy) bad++;
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.Busy) bad++;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] wa);
    logic [31:0] e1, e2;
    int n, bad;
    model(op, a, b, e1, e2);
    @(negedge clk);
    drive(1'b1, op, a, b, wa);
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    chk({tag, ":wa3r_early"}, bus.WA3R, wa);
    n = 0;
    wait_done(n, bad);
    chk({tag, ":latency"}, n, W);
    chk({tag, ":busy_done"}, bad, 0);
    chk({tag, ":r1"}, bus.Result1, e1);
    chk({tag, ":r2"}, bus.Result2, e2);
    chk({tag, ":wa3r"}, bus.WA3R, wa);
    @(posedge clk);
    #1;
    chk({tag, ":pulse"}, {bus.Done, bus.Busy}, 2'b00);
    chk({tag, ":hold"}, {bus.Result2, bus.Result1}, {e2, e1});
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b, e1, e2;
    int n, bad, dones;

    drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
    #1;
    chk("reset_ctl", {bus.Busy, bus.Done}, 2'b00);
    chk("reset_res", {bus.Result2, bus.Result1}, 64'd0);
    chk("reset_wa3r", bus.WA3R, 4'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("umul", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 4'd1);
    run_op("smul", 2'b00, 32'hFFFF_FFFD, 32'd5, 4'd2);
    run_op("sdiv", 2'b10, 32'hFFFF_FFF9, 32'd2, 4'd3);
    run_op("udiv", 2'b11, 32'd100, 32'd7, 4'd4);
    run_op("div0", 2'b11, 32'h0000_1234, 32'd0, 4'd6);
    run_op("sdiv0", 2'b10, 32'h8000_0000, 32'd0, 4'd7);
    run_op("smul_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 4'd8);
    run_op("sdiv_min", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 4'd10);

    // A second Start during COMPUTE must be ignored
    model(2'b01, 32'd1000, 32'd3000, e1, e2);
    @(negedge clk);
    drive(1'b1, 2'b01, 32'd1000, 32'd3000, 4'd5);
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    drive(1'b1, 2'b11, 32'd77, 32'd5, 4'd9);
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    chk("ign:wa3r_mid", bus.WA3R, 4'd5);
    chk("ign:busy_mid", bus.Busy, 1'b1);
    n = 10;
    wait_done(n, bad);
    chk("ign:latency", n, W);
    chk("ign:busy_done", bad, 0);
    chk("ign:wa3r", bus.WA3R, 4'd5);
    chk("ign:r1", bus.Result1, e1);
    chk("ign:r2", bus.Result2, e2);
    @(posedge clk);
    #1;

    // Reset mid-operation abandons the op without a Done pulse
    @(negedge clk);
    drive(1'b1, 2'b00, 32'd12345, 32'd678, 4'd5);
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort:ctl", {bus.Busy, bus.Done}, 2'b00);
    chk("abort:res", {bus.Result2, bus.Result1}, 64'd0);
    chk("abort:wa3r", bus.WA3R, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.Done || bus.Busy) dones++;
    end
    chk("abort:no_done", dones, 0);
    run_op("after_rst", 2'b11, 32'd1000, 32'd33, 4'd11);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
      run_op("rnd", op, a, b, 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
